// File: rtl/sm_accum_disp_amisha.sv
// Registered sign-magnitude accumulator with saturation and a sticky overflow flag,
// plus a four-digit multiplexed seven-segment display of the running total.
module sm_accum_disp_amisha #(
  parameter int N            = 8,
  parameter int REFRESH_BITS = 18
) (
  input  logic         clk_amisha,
  input  logic         reset_amisha,
  input  logic [N-1:0] in_amisha,
  input  logic         add_amisha,
  input  logic         mode_amisha,
  input  logic         clr_amisha,
  output logic [N-1:0] acc_amisha,
  output logic         ovf_amisha,
  output logic [3:0]   an_amisha,
  output logic [7:0]   sseg_amisha
);

  localparam int          M       = N - 1;
  localparam logic [M-1:0] MAX_MAG = '1;
  localparam int          NDIG    = (M + 3) / 4;
  localparam logic [2:0]  NDIG3   = 3'(NDIG);

  logic                    acc_sign;
  logic [M-1:0]            acc_mag;
  logic [REFRESH_BITS-1:0] refresh_cnt;

  logic [M-1:0] op_mag;
  logic         op_sign;
  logic [M:0]   mag_sum;
  logic [M-1:0] res_mag;
  logic         res_sign;
  logic         res_sat;

  assign acc_amisha = {acc_sign, acc_mag};

  // Subtract mode flips the operand sign; a zero magnitude is always treated as +0.
  assign op_mag  = in_amisha[M-1:0];
  assign op_sign = (in_amisha[N-1] ^ mode_amisha) && (op_mag != '0);
  assign mag_sum = {1'b0, acc_mag} + {1'b0, op_mag};

  always_comb begin
    res_mag  = acc_mag;
    res_sign = acc_sign;
    res_sat  = 1'b0;
    if (op_sign == acc_sign) begin
      if (mag_sum[M]) begin
        res_mag = MAX_MAG;
        res_sat = 1'b1;
      end else begin
        res_mag = mag_sum[M-1:0];
      end
    end else if (acc_mag >= op_mag) begin
      res_mag = acc_mag - op_mag;
    end else begin
      res_mag  = op_mag - acc_mag;
      res_sign = op_sign;
    end
    if (res_mag == '0) begin
      res_sign = 1'b0;
    end
  end

  // Reset beats clear, and clear beats add; the refresh counter runs regardless.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      acc_sign    <= 1'b0;
      acc_mag     <= '0;
      ovf_amisha  <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      if (clr_amisha) begin
        acc_sign   <= 1'b0;
        acc_mag    <= '0;
        ovf_amisha <= 1'b0;
      end else if (add_amisha) begin
        acc_sign   <= res_sign;
        acc_mag    <= res_mag;
        ovf_amisha <= ovf_amisha | res_sat;
      end
    end
  end

  function automatic logic [7:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_font = 8'hC0;
      4'h1:    hex_font = 8'hF9;
      4'h2:    hex_font = 8'hA4;
      4'h3:    hex_font = 8'hB0;
      4'h4:    hex_font = 8'h99;
      4'h5:    hex_font = 8'h92;
      4'h6:    hex_font = 8'h82;
      4'h7:    hex_font = 8'hF8;
      4'h8:    hex_font = 8'h80;
      4'h9:    hex_font = 8'h90;
      4'hA:    hex_font = 8'h88;
      4'hB:    hex_font = 8'h83;
      4'hC:    hex_font = 8'hC6;
      4'hD:    hex_font = 8'hA1;
      4'hE:    hex_font = 8'h86;
      default: hex_font = 8'h8E;
    endcase
  endfunction

  logic [1:0]  digit_sel;
  logic [11:0] mag12;

  assign digit_sel = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2];
  assign mag12     = 12'(acc_mag);

  // Digits beyond the magnitude width stay blank; digit 3 carries only the minus sign.
  always_comb begin
    an_amisha   = 4'b1111;
    sseg_amisha = 8'hFF;
    case (digit_sel)
      2'd0:    an_amisha = 4'b1110;
      2'd1:    an_amisha = 4'b1101;
      2'd2:    an_amisha = 4'b1011;
      default: an_amisha = 4'b0111;
    endcase
    if (digit_sel == 2'd3) begin
      sseg_amisha = acc_sign ? 8'hBF : 8'hFF;
    end else if ({1'b0, digit_sel} < NDIG3) begin
      sseg_amisha = hex_font(mag12[{digit_sel, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_sm_accum_disp_amisha.sv
// Scoreboard bench for sm_accum_disp_amisha (N=8, short refresh counter for fast digit sweeps).
module tb_sm_accum_disp_amisha;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_v;
  logic       add;
  logic       mode;
  logic       clr;
  logic [7:0] acc;
  logic       ovf;
  logic [3:0] an;
  logic [7:0] sseg;

  int checks   = 0;
  int failures = 0;

  logic [8:0]  acc_exp_q[$];
  logic [11:0] disp_exp_q[$];
  logic [8:0]  acc_e;
  logic [11:0] disp_e;
  logic        cmd_q    = 1'b0;
  logic        disp_req = 1'b0;
  logic [3:0]  tb_cnt   = 4'd0;

  sm_accum_disp_amisha #(.N(8), .REFRESH_BITS(4)) dut (
    .clk_amisha  (clk),
    .reset_amisha(reset),
    .in_amisha   (in_v),
    .add_amisha  (add),
    .mode_amisha (mode),
    .clr_amisha  (clr),
    .acc_amisha  (acc),
    .ovf_amisha  (ovf),
    .an_amisha   (an),
    .sseg_amisha (sseg)
  );

  always #5 clk = ~clk;

  // Independent model of the refresh counter; it tracks which digit should be lit.
  always @(posedge clk) begin
    cmd_q <= reset | add | clr;
    if (reset) tb_cnt <= 4'd0;
    else       tb_cnt <= tb_cnt + 4'd1;
  end

  // Monitor: pops expectations whenever the DUT has just taken a command or a display check is armed.
  always @(negedge clk) begin
    if (cmd_q) begin
      checks++;
      if (acc_exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL acc_queue_empty acc=%h ovf=%b", acc, ovf);
      end else begin
        acc_e = acc_exp_q.pop_front();
        if (acc !== acc_e[8:1]) begin
          failures++;
          $display("[TB] FAIL acc got=%h exp=%h", acc, acc_e[8:1]);
        end
        checks++;
        if (ovf !== acc_e[0]) begin
          failures++;
          $display("[TB] FAIL ovf got=%b exp=%b (acc=%h)", ovf, acc_e[0], acc);
        end
      end
    end
    if (disp_req) begin
      checks++;
      if (disp_exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL disp_queue_empty an=%b sseg=%h", an, sseg);
      end else begin
        disp_e = disp_exp_q.pop_front();
        if (an !== disp_e[11:8]) begin
          failures++;
          $display("[TB] FAIL an got=%b exp=%b", an, disp_e[11:8]);
        end
        checks++;
        if (sseg !== disp_e[7:0]) begin
          failures++;
          $display("[TB] FAIL sseg got=%h exp=%h (an=%b)", sseg, disp_e[7:0], an);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic c, input logic a, input logic m,
                               input logic [7:0] op, input logic [7:0] exp_acc, input logic exp_ovf);
    reset = rst;
    clr   = c;
    add   = a;
    mode  = m;
    in_v  = op;
    acc_exp_q.push_back({exp_acc, exp_ovf});
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr   = 1'b0;
    add   = 1'b0;
    mode  = 1'b0;
    in_v  = 8'h00;
  endtask

  task automatic checkOutput(input logic [1:0] digit, input logic [3:0] exp_an, input logic [7:0] exp_sseg);
    int guard = 0;
    while (tb_cnt[3:2] != digit && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (tb_cnt[3:2] != digit) begin
      checks++;
      failures++;
      $display("[TB] FAIL digit_wait timeout digit=%0d", digit);
    end else begin
      disp_exp_q.push_back({exp_an, exp_sseg});
      disp_req = 1'b1;
      @(posedge clk);
      #1;
      disp_req = 1'b0;
    end
  endtask

  logic [3:0] sweep_an[4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] sweep_sseg[4] = '{8'h88, 8'h92, 8'hFF, 8'hBF};

  initial begin
    int guard;
    reset = 1'b0; clr = 1'b0; add = 1'b0; mode = 1'b0; in_v = 8'h00;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 0);
    checkOutput(2'd0, 4'b1110, 8'hC0);

    $display("[TB] mixed signs");
    applyStimulus(0, 0, 1, 0, 8'h05, 8'h05, 0);
    applyStimulus(0, 0, 1, 0, 8'h8C, 8'h87, 0);
    checkOutput(2'd0, 4'b1110, 8'hF8);
    checkOutput(2'd1, 4'b1101, 8'hC0);
    checkOutput(2'd2, 4'b1011, 8'hFF);
    checkOutput(2'd3, 4'b0111, 8'hBF);
    applyStimulus(0, 0, 1, 0, 8'h0A, 8'h03, 0);

    $display("[TB] saturation");
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'h64, 8'h64, 0);
    applyStimulus(0, 0, 1, 0, 8'h64, 8'h7F, 1);
    applyStimulus(0, 0, 1, 0, 8'h81, 8'h7E, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'hFF, 8'hFF, 0);
    applyStimulus(0, 0, 1, 0, 8'h81, 8'hFF, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00, 0);

    $display("[TB] zero handling");
    applyStimulus(0, 0, 1, 0, 8'h03, 8'h03, 0);
    applyStimulus(0, 0, 1, 1, 8'h03, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'h80, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'h05, 8'h05, 0);
    applyStimulus(0, 0, 1, 0, 8'h80, 8'h05, 0);
    applyStimulus(0, 0, 1, 1, 8'h85, 8'h0A, 0);
    applyStimulus(0, 0, 1, 1, 8'h0A, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'h83, 8'h83, 0);
    applyStimulus(0, 0, 1, 0, 8'h05, 8'h02, 0);
    applyStimulus(0, 0, 1, 0, 8'h02, 8'h04, 0);
    applyStimulus(0, 0, 1, 0, 8'h02, 8'h06, 0);

    $display("[TB] priority");
    applyStimulus(0, 1, 1, 0, 8'h10, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'h10, 8'h10, 0);
    applyStimulus(1, 0, 1, 0, 8'h10, 8'h00, 0);
    applyStimulus(0, 0, 1, 0, 8'h7F, 8'h7F, 0);
    applyStimulus(0, 0, 1, 0, 8'h01, 8'h7F, 1);
    applyStimulus(1, 1, 1, 0, 8'h01, 8'h00, 0);

    $display("[TB] mux sweep");
    applyStimulus(0, 0, 1, 0, 8'hDA, 8'hDA, 0);
    guard = 0;
    while (tb_cnt != 4'd0 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (tb_cnt != 4'd0) begin
      checks++;
      failures++;
      $display("[TB] FAIL sweep_align timeout");
    end else begin
      for (int i = 0; i < 17; i++) begin
        disp_exp_q.push_back({sweep_an[(i / 4) % 4], sweep_sseg[(i / 4) % 4]});
        disp_req = 1'b1;
        @(posedge clk);
        #1;
      end
      disp_req = 1'b0;
    end

    @(negedge clk);
    #1;
    checks++;
    if (acc_exp_q.size() != 0 || disp_exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL leftover_expectations acc_q=%0d disp_q=%0d", acc_exp_q.size(), disp_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule
